// File: rtl/go_text_pkg.sv
// Shared constants for the "GAME OVER" text overlay: letter codes, string, glyph geometry, FSM states.
package go_text_pkg;

  localparam int unsigned STR_LEN = 9;
  localparam int unsigned GLYPH_W = 16;
  localparam int unsigned GLYPH_H = 16;

  localparam logic [3:0] CODE_SPACE = 4'd0;
  localparam logic [3:0] CODE_G     = 4'd1;
  localparam logic [3:0] CODE_A     = 4'd2;
  localparam logic [3:0] CODE_M     = 4'd3;
  localparam logic [3:0] CODE_E     = 4'd4;
  localparam logic [3:0] CODE_O     = 4'd5;
  localparam logic [3:0] CODE_V     = 4'd6;
  localparam logic [3:0] CODE_R     = 4'd7;

  localparam logic [3:0] GO_STRING [STR_LEN] = '{
    CODE_G, CODE_A, CODE_M, CODE_E, CODE_SPACE, CODE_O, CODE_V, CODE_E, CODE_R
  };

  typedef enum logic [1:0] {IDLE, REVEAL, SHOW} go_state_e;

  // Indices past the end of the string map to the blank glyph.
  function automatic logic [3:0] char_code(input logic [3:0] idx);
    logic [3:0] code;
    code = CODE_SPACE;
    for (int i = 0; i < int'(STR_LEN); i++) begin
      if (idx == 4'(i)) code = GO_STRING[i];
    end
    return code;
  endfunction

endpackage

// File: rtl/frame_divider.sv
// Counts frame ticks up to a terminal value; pulses expire on the tick that wraps the count.
module frame_divider (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       tick,
  input  logic [7:0] term,
  output logic       expire
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    expire = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q == term) begin
        cnt_d  = '0;
        expire = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/game_over_text_ctrl.sv
// Draws "GAME OVER" from an external registered glyph ROM, revealing one letter per frame period.
// Define GO_TEXT_BLINK_EN to blink the text once fully shown.
module game_over_text_ctrl
  import go_text_pkg::*;
#(
  parameter logic [9:0] X0            = 10'd248,
  parameter logic [9:0] Y0            = 10'd232,
  parameter logic [7:0] REVEAL_FRAMES = 8'd8,
  parameter logic [7:0] BLINK_FRAMES  = 8'd30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        clear,
  input  logic        frame_tick,
  input  logic        pix_valid,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic        pixel_on,
  output logic        busy,
  output logic        done
);

  go_state_e  state_q, state_d;
  logic [3:0] revealed_q, revealed_d;
  logic       reveal_clr, reveal_exp;
  logic       show_vis;

  assign reveal_clr = (state_q != REVEAL) | start | clear;

  frame_divider u_reveal_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (reveal_clr),
    .tick   (frame_tick),
    .term   (REVEAL_FRAMES - 8'd1),
    .expire (reveal_exp)
  );

`ifdef GO_TEXT_BLINK_EN
  logic blink_clr, blink_exp, phase_q;

  assign blink_clr = (state_q != SHOW) | start | clear;

  frame_divider u_blink_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (blink_clr),
    .tick   (frame_tick),
    .term   (BLINK_FRAMES - 8'd1),
    .expire (blink_exp)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || blink_clr) phase_q <= 1'b0;
    else if (blink_exp)      phase_q <= ~phase_q;
  end

  assign show_vis = ~phase_q;
`else
  logic unused_blink;
  assign unused_blink = ^BLINK_FRAMES;
  assign show_vis     = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      revealed_q <= '0;
    end else begin
      state_q    <= state_d;
      revealed_q <= revealed_d;
    end
  end

  // clear dominates start; the last reveal step moves straight into SHOW.
  always_comb begin
    state_d    = state_q;
    revealed_d = revealed_q;
    if (clear) begin
      state_d    = IDLE;
      revealed_d = '0;
    end else if (start) begin
      state_d    = REVEAL;
      revealed_d = '0;
    end else if (state_q == REVEAL && reveal_exp) begin
      if (revealed_q >= 4'(STR_LEN - 1)) begin
        revealed_d = 4'(STR_LEN);
        state_d    = SHOW;
      end else begin
        revealed_d = revealed_q + 4'd1;
      end
    end
  end

  logic [9:0] dx, dy;
  logic [3:0] char_idx;
  logic       in_box, visible;

  always_comb begin
    dx       = pix_x - X0;
    dy       = pix_y - Y0;
    char_idx = dx[7:4];
    in_box   = pix_valid & (pix_x >= X0) & (dx < 10'(STR_LEN * GLYPH_W))
             & (pix_y >= Y0) & (dy < 10'(GLYPH_H));
    busy     = (state_q == REVEAL);
    done     = (state_q == SHOW);
    unique case (state_q)
      REVEAL:  visible = (char_idx < revealed_q);
      SHOW:    visible = show_vis;
      default: visible = 1'b0;
    endcase
  end

  // Sidebands ride two stages to line up with the ROM's registered output.
  logic       in_box_d1, in_box_d2, vis_d1, vis_d2;
  logic [3:0] col_d1, col_d2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rom_addr  <= '0;
      in_box_d1 <= 1'b0;
      vis_d1    <= 1'b0;
      col_d1    <= '0;
      in_box_d2 <= 1'b0;
      vis_d2    <= 1'b0;
      col_d2    <= '0;
      pixel_on  <= 1'b0;
    end else begin
      rom_addr  <= in_box ? {char_code(char_idx), dy[3:0]} : 8'h00;
      in_box_d1 <= in_box;
      vis_d1    <= visible;
      col_d1    <= dx[3:0];
      in_box_d2 <= in_box_d1;
      vis_d2    <= vis_d1;
      col_d2    <= col_d1;
      pixel_on  <= in_box_d2 & vis_d2 & rom_data[4'd15 - col_d2];
    end
  end

endmodule
